mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
Multi-cycle main controller that sequences the MIPS datapath (ifu/grf/alu/dm/ext plus muxes) through FETCH/DECODE/EXE/MEM/WB states.
- Decodes opcode/funct of the instruction register.
- Drives every datapath select and write strobe per state.
- Exposes a retired-instruction pulse and a counter.
- Sits beside the datapath in the top-level CPU, replacing the single-cycle combinational control.

Parameters:
CNT_W, 32, width of retired-instruction counter instr_cnt.

Ports:
clk  input  1  system clock, all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
opcode  input  6  Instr[31:26] from instruction register.
funct  input  6  Instr[5:0] from instruction register.
ComResult  input  1  ALU equality result (rs==rt), valid in EXE.
PCWr  output  1  PC write enable.
IRWr  output  1  instruction register write enable.
nPC_sel  output  1  select branch target (beq).
Jump  output  1  select j/jal target.
JReg  output  1  select rs as next PC (jr/jalr).
RegDst  output  1  0=rt, 1=rd destination.
RegRa  output  1  force destination $31 and write PC+4 (jal).
Jalr  output  1  write PC+4 to rd (jalr).
ALUSrc  output  1  0=rt data, 1=extended immediate.
ExtOp  output  1  1=sign-extend, 0=zero-extend.
ALUOp  output  3  000 ADD, 001 SUB, 010 OR, 011 LUI, 100 SLL.
MemtoReg  output  1  write-back DM data.
Lb  output  1  byte load with sign extension.
MemWrite  output  1  DM write enable.
RegWrite  output  1  GRF write enable.
state  output  3  current state encoding, for debug.
instr_done  output  1  one-cycle pulse on the last cycle of each instruction.
instr_cnt  output  CNT_W  retired-instruction count.

Behaviour:
- Reset is asynchronous, active-high: state=FETCH, instr_cnt=0.
- While reset is high, all write strobes (PCWr, IRWr, MemWrite, RegWrite) and instr_done are forced to 0.
- Selects default to 0 outside the states listed below.
- State encoding: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4. Codes 5-7 go to FETCH on the next edge with no strobes.
- Outputs are combinational from the registered state plus opcode/funct/ComResult. opcode/funct are stable because IRWr asserts only in FETCH.
- FETCH: IRWr=1, PCWr=1 (PC+4). Next state DECODE.
- DECODE:
  - j: PCWr=1, Jump=1.
  - jal: PCWr=1, Jump=1, RegRa=1, RegWrite=1.
  - jr: PCWr=1, JReg=1.
  - jalr: PCWr=1, JReg=1, Jalr=1, RegDst=1, RegWrite=1.
  - For all four: instr_done=1, next state FETCH.
  - Unrecognised opcode/funct: no strobes, instr_done=1, next state FETCH (treated as nop).
  - All other instructions: next state EXE.
- EXE, ALU inputs held valid for all of EXE/MEM/WB:
  - addu: ALUOp=ADD. subu: ALUOp=SUB. sll: ALUOp=SLL. All three use RegDst=1.
  - ori: ALUOp=OR, ALUSrc=1, ExtOp=0.
  - lui: ALUOp=LUI, ALUSrc=1.
  - lw/lb/sw: ALUOp=ADD, ALUSrc=1, ExtOp=1.
  - beq: ALUOp=SUB, nPC_sel=1, ExtOp=1, PCWr=ComResult, instr_done=1, next state FETCH.
  - R-type/ori/lui next state WB; loads/stores next state MEM.
- MEM:
  - sw: MemWrite=1, instr_done=1, next state FETCH.
  - lw/lb: Lb=1 for lb, next state WB.
- WB: RegWrite=1, MemtoReg=1 for loads, RegDst per class; instr_done=1, next state FETCH.
- Cycle counts: j/jal/jr/jalr/illegal 2; beq 3; R/ori/lui 4; sw 4; lw/lb 5.
- instr_cnt increments by 1 on each edge where instr_done=1 and wraps modulo 2^CNT_W.
- sll with all-zero instruction (nop) executes normally. Its write targets $0, which the GRF discards.
- Reset mid-instruction: the partial instruction is abandoned, no further strobes; restart in FETCH.

Decomposition:
- Package mc_defs: state codes, opcode/funct constants, ALUOp codes.
- Sub-module mc_decode: combinational opcode/funct -> one-hot instruction class (rtype_alu, ori, lui, load, lb, store, beq, j, jal, jr, jalr, illegal). Instantiated once in mc_ctrl.

Test Plan:
- addu (op 000000, funct 100001) after reset -> states 0,1,2,4; RegWrite=1 and RegDst=1 only in WB; instr_done in cycle 4; instr_cnt=1.
- lw (op 100011) -> states 0,1,2,3,4; ALUSrc=1, ExtOp=1 in EXE; MemtoReg=1, RegWrite=1 in WB; lb (100000) same with Lb=1 in MEM/WB.
- sw (op 101011) -> MemWrite=1 only in MEM (cycle 4), RegWrite never asserted, back to FETCH.
- beq (op 000100): ComResult=1 -> PCWr=1, nPC_sel=1 in EXE; ComResult=0 -> PCWr=0; both complete in 3 cycles.
- jal (op 000011) -> DECODE drives PCWr, Jump, RegRa, RegWrite all 1; 2 cycles. Illegal opcode 111111 -> 2 cycles, no strobes, instr_cnt still increments.
- Assert reset during MEM of sw -> MemWrite drops immediately, state=0, instr_cnt=0; after release, FETCH strobes resume on the next cycle.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state codes,
// opcode/funct constants, ALU operation codes and the instruction-class type.
package mc_defs;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXE    = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_LUI  = 3'b011;
  localparam logic [2:0] ALU_SLL  = 3'b100;

  // Exactly one field is set for any opcode/funct pair.
  typedef struct packed {
    logic rtype_alu;  // addu, subu, sll
    logic ori;
    logic lui;
    logic load;       // lw
    logic lb;
    logic store;      // sw
    logic beq;
    logic j;
    logic jal;
    logic jr;
    logic jalr;
    logic illegal;
  } instr_class_t;

  // ALU operation for the register-register ALU group.
  function automatic logic [2:0] rtype_aluop(input logic [5:0] fn);
    case (fn)
      FN_SUBU: rtype_aluop = ALU_SUB;
      FN_SLL:  rtype_aluop = ALU_SLL;
      default: rtype_aluop = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct -> one-hot class.
module mc_decode
  import mc_defs::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t cls
);

  // Anything not explicitly recognised falls into the illegal class.
  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU, FN_SLL: cls.rtype_alu = 1'b1;
          FN_JR:                    cls.jr        = 1'b1;
          FN_JALR:                  cls.jalr      = 1'b1;
          default:                  cls.illegal   = 1'b1;
        endcase
      end
      OP_ORI:  cls.ori     = 1'b1;
      OP_LUI:  cls.lui     = 1'b1;
      OP_LW:   cls.load    = 1'b1;
      OP_LB:   cls.lb      = 1'b1;
      OP_SW:   cls.store   = 1'b1;
      OP_BEQ:  cls.beq     = 1'b1;
      OP_J:    cls.j       = 1'b1;
      OP_JAL:  cls.jal     = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller. Sequences FETCH/DECODE/EXE/MEM/WB,
// drives datapath selects and strobes from the registered state, and counts
// retired instructions.
module mc_ctrl
  import mc_defs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             ComResult,
  output logic             PCWr,
  output logic             IRWr,
  output logic             nPC_sel,
  output logic             Jump,
  output logic             JReg,
  output logic             RegDst,
  output logic             RegRa,
  output logic             Jalr,
  output logic             ALUSrc,
  output logic             ExtOp,
  output logic [2:0]       ALUOp,
  output logic             MemtoReg,
  output logic             Lb,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  instr_class_t     cls;

  // Ungated strobes from the state decode; reset masks them below.
  logic pc_wr, ir_wr, mem_wr, reg_wr, done;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls)
  );

  // Next-state and per-state select/strobe decode.
  always_comb begin
    state_d  = ST_FETCH;
    pc_wr    = 1'b0;
    ir_wr    = 1'b0;
    mem_wr   = 1'b0;
    reg_wr   = 1'b0;
    done     = 1'b0;
    nPC_sel  = 1'b0;
    Jump     = 1'b0;
    JReg     = 1'b0;
    RegDst   = 1'b0;
    RegRa    = 1'b0;
    Jalr     = 1'b0;
    ALUSrc   = 1'b0;
    ExtOp    = 1'b0;
    ALUOp    = ALU_ADD;
    MemtoReg = 1'b0;
    Lb       = 1'b0;

    case (state_q)
      ST_FETCH: begin
        ir_wr   = 1'b1;
        pc_wr   = 1'b1;
        state_d = ST_DECODE;
      end

      ST_DECODE: begin
        state_d = ST_EXE;
        if (cls.j || cls.jal) begin
          pc_wr = 1'b1;
          Jump  = 1'b1;
          RegRa = cls.jal;
          reg_wr = cls.jal;
        end
        if (cls.jr || cls.jalr) begin
          pc_wr  = 1'b1;
          JReg   = 1'b1;
          Jalr   = cls.jalr;
          RegDst = cls.jalr;
          reg_wr = cls.jalr;
        end
        // Jumps and unrecognised encodings finish here.
        if (cls.j || cls.jal || cls.jr || cls.jalr || cls.illegal) begin
          done    = 1'b1;
          state_d = ST_FETCH;
        end
      end

      ST_EXE, ST_MEM, ST_WB: begin
        // ALU controls stay stable for the rest of the instruction so the
        // datapath result does not move between EXE and WB.
        if (cls.rtype_alu) begin
          ALUOp  = rtype_aluop(funct);
          RegDst = 1'b1;
        end
        if (cls.ori) begin
          ALUOp  = ALU_OR;
          ALUSrc = 1'b1;
        end
        if (cls.lui) begin
          ALUOp  = ALU_LUI;
          ALUSrc = 1'b1;
        end
        if (cls.load || cls.lb || cls.store) begin
          ALUOp  = ALU_ADD;
          ALUSrc = 1'b1;
          ExtOp  = 1'b1;
        end
        if (cls.beq) begin
          ALUOp  = ALU_SUB;
          ExtOp  = 1'b1;
        end

        if (state_q == ST_EXE) begin
          if (cls.beq) begin
            nPC_sel = 1'b1;
            pc_wr   = ComResult;
            done    = 1'b1;
            state_d = ST_FETCH;
          end else if (cls.load || cls.lb || cls.store) begin
            state_d = ST_MEM;
          end else begin
            state_d = ST_WB;
          end
        end else if (state_q == ST_MEM) begin
          if (cls.store) begin
            mem_wr  = 1'b1;
            done    = 1'b1;
            state_d = ST_FETCH;
          end else begin
            Lb      = cls.lb;
            state_d = ST_WB;
          end
        end else begin
          reg_wr   = 1'b1;
          MemtoReg = cls.load || cls.lb;
          Lb       = cls.lb;
          done     = 1'b1;
          state_d  = ST_FETCH;
        end
      end

      // Unused codes recover to FETCH without touching the datapath.
      default: state_d = ST_FETCH;
    endcase
  end

  // Reset masks every write strobe and the retire pulse immediately.
  always_comb begin
    PCWr       = pc_wr  & ~reset;
    IRWr       = ir_wr  & ~reset;
    MemWrite   = mem_wr & ~reset;
    RegWrite   = reg_wr & ~reset;
    instr_done = done   & ~reset;
    cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, instr_done};
  end

  // State and retired-instruction counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule
